// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-style controller: state codes, opcodes,
// funct codes, ALU control codes and datapath mux selects.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StExecR   = 4'd2,
    StExecI   = 4'd3,
    StWbAlu   = 4'd4,
    StMemAddr = 4'd5,
    StMemRd   = 4'd6,
    StMemWb   = 4'd7,
    StMemWr   = 4'd8,
    StBranch  = 4'd9,
    StJump    = 4'd10,
    StJr      = 4'd11,
    StTrap    = 4'd15
  } state_e;

  // Variable shifts reuse SLL/SRL; the datapath picks shamt vs rs[4:0].
  typedef enum logic [3:0] {
    AluAnd = 4'b0000,
    AluOr  = 4'b0001,
    AluAdd = 4'b0010,
    AluSub = 4'b0110,
    AluSlt = 4'b0111,
    AluSll = 4'b1000,
    AluSrl = 4'b1001,
    AluMul = 4'b1010,
    AluLui = 4'b1011
  } alu_op_e;

  // Opcodes (instr[31:26]). BGEZ is encoded with rt = r0 so SUB passes rs.
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpBgez  = 6'b000001;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBnez  = 6'b000101;
  localparam logic [5:0] OpBgt   = 6'b000111;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  // Funct codes (instr[5:0]).
  localparam logic [5:0] FnSll  = 6'b000000;
  localparam logic [5:0] FnSrl  = 6'b000010;
  localparam logic [5:0] FnSllv = 6'b000100;
  localparam logic [5:0] FnSrlv = 6'b000110;
  localparam logic [5:0] FnJr   = 6'b001000;
  localparam logic [5:0] FnMul  = 6'b011000;
  localparam logic [5:0] FnAdd  = 6'b100000;
  localparam logic [5:0] FnSub  = 6'b100010;
  localparam logic [5:0] FnAnd  = 6'b100100;
  localparam logic [5:0] FnOr   = 6'b100101;
  localparam logic [5:0] FnSlt  = 6'b101010;

  // Datapath mux selects.
  localparam logic [1:0] SrcBRt    = 2'd0;
  localparam logic [1:0] SrcBFour  = 2'd1;
  localparam logic [1:0] SrcBImm   = 2'd2;
  localparam logic [1:0] SrcBImmSh = 2'd3;
  localparam logic [1:0] PcSrcAlu  = 2'd0;
  localparam logic [1:0] PcSrcTgt  = 2'd1;
  localparam logic [1:0] PcSrcJmp  = 2'd2;
  localparam logic [1:0] PcSrcRs   = 2'd3;
  localparam logic [1:0] RegDstRt  = 2'd0;
  localparam logic [1:0] RegDstRd  = 2'd1;
  localparam logic [1:0] RegDstR31 = 2'd2;
  localparam logic [1:0] WbAlu     = 2'd0;
  localparam logic [1:0] WbMem     = 2'd1;
  localparam logic [1:0] WbPc      = 2'd2;

  function automatic logic is_branch_op(logic [5:0] op);
    return (op == OpBeq) || (op == OpBnez) || (op == OpBgt) || (op == OpBgez);
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// R-type funct to ALU control decoder; valid_o flags funct codes the ALU supports.
module alu_ctrl_dec
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct_i,
  output alu_op_e    alu_ctrl_o,
  output logic       valid_o
);

  // Map funct to ALU operation, flag unsupported codes.
  always_comb begin
    alu_ctrl_o = AluAdd;
    valid_o    = 1'b1;
    case (funct_i)
      FnAdd:          alu_ctrl_o = AluAdd;
      FnSub:          alu_ctrl_o = AluSub;
      FnAnd:          alu_ctrl_o = AluAnd;
      FnOr:           alu_ctrl_o = AluOr;
      FnSlt:          alu_ctrl_o = AluSlt;
      FnSll, FnSllv:  alu_ctrl_o = AluSll;
      FnSrl, FnSrlv:  alu_ctrl_o = AluSrl;
      FnMul:          alu_ctrl_o = AluMul;
      default:        valid_o    = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM. Optional feature macro MEM_WAIT_EN: memory
// states wait for mem_ready_i and trap after MEM_TIMEOUT cycles without it.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       neg_i,
  input  logic       mem_ready_i,
  output logic       pc_we_o,
  output logic       ir_we_o,
  output logic       rf_we_o,
  output logic       mem_rd_o,
  output logic       mem_wr_o,
  output logic       tgt_we_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [3:0] alu_ctrl_o,
  output logic [1:0] pc_src_o,
  output logic [1:0] reg_dst_o,
  output logic [1:0] wb_src_o,
  output logic [3:0] state_o,
  output logic       trap_o
);

  state_e  r_state, w_state_next;
  alu_op_e w_dec_alu;
  logic    w_dec_valid, w_br_taken, w_mem_done, w_mem_timeout;
  logic    w_pc_we, w_ir_we, w_rf_we, w_mem_rd, w_mem_wr, w_tgt_we;

  alu_ctrl_dec u_alu_ctrl_dec (
    .funct_i    (funct_i),
    .alu_ctrl_o (w_dec_alu),
    .valid_o    (w_dec_valid)
  );

`ifdef MEM_WAIT_EN
  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);
  logic [CntW-1:0] r_wait_cnt;

  // Count stalled cycles in a memory state; cleared whenever not stalling.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if ((r_state == StMemRd || r_state == StMemWr) && !mem_ready_i) begin
      r_wait_cnt <= r_wait_cnt + CntW'(1);
    end else begin
      r_wait_cnt <= '0;
    end
  end

  assign w_mem_done    = mem_ready_i;
  assign w_mem_timeout = (r_wait_cnt == CntW'(MEM_TIMEOUT - 1));
`else
  logic        unused_mem_ready;
  logic [31:0] unused_timeout;
  assign unused_mem_ready = mem_ready_i;
  assign unused_timeout   = MEM_TIMEOUT;
  assign w_mem_done       = 1'b1;
  assign w_mem_timeout    = 1'b0;
`endif

  // Branch condition from ALU flags of rs - rt.
  always_comb begin
    w_br_taken = 1'b0;
    case (op_i)
      OpBeq:   w_br_taken = zero_i;
      OpBnez:  w_br_taken = !zero_i;
      OpBgt:   w_br_taken = !zero_i && !neg_i;
      OpBgez:  w_br_taken = !neg_i;
      default: w_br_taken = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) r_state <= StFetch;
    else        r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StFetch:  w_state_next = StDecode;
      StDecode: begin
        if (op_i == OpRtype) begin
          w_state_next = (funct_i == FnJr) ? StJr : StExecR;
        end else if (op_i == OpAddi || op_i == OpOri || op_i == OpLui) begin
          w_state_next = StExecI;
        end else if (op_i == OpLw || op_i == OpSw) begin
          w_state_next = StMemAddr;
        end else if (is_branch_op(op_i)) begin
          w_state_next = StBranch;
        end else if (op_i == OpJ || op_i == OpJal) begin
          w_state_next = StJump;
        end else begin
          w_state_next = StTrap;
        end
      end
      StExecR:   w_state_next = w_dec_valid ? StWbAlu : StTrap;
      StExecI:   w_state_next = StWbAlu;
      StMemAddr: w_state_next = (op_i == OpLw) ? StMemRd : StMemWr;
      // Ready takes priority over a simultaneous timeout.
      StMemRd: begin
        if (w_mem_done)         w_state_next = StMemWb;
        else if (w_mem_timeout) w_state_next = StTrap;
      end
      StMemWr: begin
        if (w_mem_done)         w_state_next = StFetch;
        else if (w_mem_timeout) w_state_next = StTrap;
      end
      StWbAlu, StMemWb, StBranch, StJump, StJr: w_state_next = StFetch;
      StTrap:  w_state_next = StTrap;
      default: w_state_next = StTrap;
    endcase
  end

  // Output decode; unlisted enables stay 0.
  always_comb begin
    w_pc_we     = 1'b0;
    w_ir_we     = 1'b0;
    w_rf_we     = 1'b0;
    w_mem_rd    = 1'b0;
    w_mem_wr    = 1'b0;
    w_tgt_we    = 1'b0;
    alu_src_a_o = 1'b0;
    alu_src_b_o = SrcBRt;
    alu_ctrl_o  = AluAdd;
    pc_src_o    = PcSrcAlu;
    reg_dst_o   = RegDstRt;
    wb_src_o    = WbAlu;
    case (r_state)
      StFetch: begin
        w_ir_we     = 1'b1;
        w_pc_we     = 1'b1;
        alu_src_b_o = SrcBFour;
      end
      StDecode: begin
        w_tgt_we    = 1'b1;
        alu_src_b_o = SrcBImmSh;
      end
      StExecR: begin
        alu_src_a_o = 1'b1;
        alu_ctrl_o  = w_dec_alu;
      end
      StExecI: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SrcBImm;
        if (op_i == OpOri)      alu_ctrl_o = AluOr;
        else if (op_i == OpLui) alu_ctrl_o = AluLui;
      end
      StWbAlu: begin
        w_rf_we   = 1'b1;
        reg_dst_o = (op_i == OpRtype) ? RegDstRd : RegDstRt;
      end
      StMemAddr: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SrcBImm;
      end
      StMemRd: w_mem_rd = 1'b1;
      StMemWb: begin
        w_rf_we  = 1'b1;
        wb_src_o = WbMem;
      end
      StMemWr: w_mem_wr = 1'b1;
      StBranch: begin
        alu_src_a_o = 1'b1;
        alu_ctrl_o  = AluSub;
        pc_src_o    = PcSrcTgt;
        w_pc_we     = w_br_taken;
      end
      StJump: begin
        w_pc_we  = 1'b1;
        pc_src_o = PcSrcJmp;
        if (op_i == OpJal) begin
          w_rf_we   = 1'b1;
          reg_dst_o = RegDstR31;
          wb_src_o  = WbPc;
        end
      end
      StJr: begin
        w_pc_we  = 1'b1;
        pc_src_o = PcSrcRs;
      end
      default: ;
    endcase
  end

  // Reset masks enables at once so an aborted instruction writes nothing.
  assign pc_we_o  = w_pc_we  & rst_n;
  assign ir_we_o  = w_ir_we  & rst_n;
  assign rf_we_o  = w_rf_we  & rst_n;
  assign mem_rd_o = w_mem_rd & rst_n;
  assign mem_wr_o = w_mem_wr & rst_n;
  assign tgt_we_o = w_tgt_we & rst_n;
  assign state_o  = r_state;
  assign trap_o   = (r_state == StTrap);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver queues the expected per-cycle
// control bundle, the monitor pops and compares it at each sample point.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] op = '0, funct = '0;
  logic       zero = 1'b0, neg = 1'b0, mem_ready = 1'b0;
  logic       pc_we, ir_we, rf_we, mem_rd, mem_wr, tgt_we, alu_src_a, trap;
  logic [1:0] alu_src_b, pc_src, reg_dst, wb_src;
  logic [3:0] alu_ctrl, state;

  int n_checks = 0;
  int n_pass   = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
    .clk_i       (clk),
    .rst_n       (rst_n),
    .op_i        (op),
    .funct_i     (funct),
    .zero_i      (zero),
    .neg_i       (neg),
    .mem_ready_i (mem_ready),
    .pc_we_o     (pc_we),
    .ir_we_o     (ir_we),
    .rf_we_o     (rf_we),
    .mem_rd_o    (mem_rd),
    .mem_wr_o    (mem_wr),
    .tgt_we_o    (tgt_we),
    .alu_src_a_o (alu_src_a),
    .alu_src_b_o (alu_src_b),
    .alu_ctrl_o  (alu_ctrl),
    .pc_src_o    (pc_src),
    .reg_dst_o   (reg_dst),
    .wb_src_o    (wb_src),
    .state_o     (state),
    .trap_o      (trap)
  );

  always #5 clk = ~clk;

  // chk[2]: alu_src_a/b + alu_ctrl, chk[1]: pc_src, chk[0]: reg_dst + wb_src
  typedef struct {
    string      name;
    logic [3:0] st;
    logic [5:0] en;   // {pc, ir, rf, mem_rd, mem_wr, tgt}
    logic       trap;
    logic [2:0] chk;
    logic       a;
    logic [1:0] b;
    logic [3:0] alu;
    logic [1:0] pcs, rdst, wbs;
  } exp_t;

  exp_t q[$];

  localparam logic [5:0] EnPc = 6'b100000, EnIr = 6'b010000, EnRf = 6'b001000;
  localparam logic [5:0] EnRd = 6'b000100, EnWr = 6'b000010, EnTgt = 6'b000001;

  function automatic exp_t mk(string n, logic [3:0] st, logic [5:0] en, logic tr,
                              logic [2:0] chk, logic a, logic [1:0] b, logic [3:0] alu,
                              logic [1:0] pcs, logic [1:0] rdst, logic [1:0] wbs);
    exp_t e;
    e.name = n; e.st = st; e.en = en; e.trap = tr; e.chk = chk; e.a = a; e.b = b;
    e.alu = alu; e.pcs = pcs; e.rdst = rdst; e.wbs = wbs;
    return e;
  endfunction

  function automatic exp_t e_fetch(string n);
    return mk({n, ".fetch"}, 4'd0, EnPc | EnIr, 1'b0, 3'b110, 1'b0, 2'd1, 4'b0010, 2'd0, 2'd0, 2'd0);
  endfunction
  function automatic exp_t e_decode(string n);
    return mk({n, ".decode"}, 4'd1, EnTgt, 1'b0, 3'b100, 1'b0, 2'd3, 4'b0010, 2'd0, 2'd0, 2'd0);
  endfunction
  function automatic exp_t e_exec_r(string n, logic [3:0] alu);
    return mk({n, ".exec_r"}, 4'd2, 6'd0, 1'b0, 3'b100, 1'b1, 2'd0, alu, 2'd0, 2'd0, 2'd0);
  endfunction
  function automatic exp_t e_exec_i(string n, logic [3:0] alu);
    return mk({n, ".exec_i"}, 4'd3, 6'd0, 1'b0, 3'b100, 1'b1, 2'd2, alu, 2'd0, 2'd0, 2'd0);
  endfunction
  function automatic exp_t e_wb_alu(string n, logic [1:0] rd);
    return mk({n, ".wb_alu"}, 4'd4, EnRf, 1'b0, 3'b001, 1'b0, 2'd0, 4'd0, 2'd0, rd, 2'd0);
  endfunction
  function automatic exp_t e_mem_addr(string n);
    return mk({n, ".mem_addr"}, 4'd5, 6'd0, 1'b0, 3'b100, 1'b1, 2'd2, 4'b0010, 2'd0, 2'd0, 2'd0);
  endfunction
  function automatic exp_t e_mem_rd(string n);
    return mk({n, ".mem_rd"}, 4'd6, EnRd, 1'b0, 3'b000, 1'b0, 2'd0, 4'd0, 2'd0, 2'd0, 2'd0);
  endfunction
  function automatic exp_t e_mem_wb(string n);
    return mk({n, ".mem_wb"}, 4'd7, EnRf, 1'b0, 3'b001, 1'b0, 2'd0, 4'd0, 2'd0, 2'd0, 2'd1);
  endfunction
  function automatic exp_t e_mem_wr(string n);
    return mk({n, ".mem_wr"}, 4'd8, EnWr, 1'b0, 3'b000, 1'b0, 2'd0, 4'd0, 2'd0, 2'd0, 2'd0);
  endfunction
  function automatic exp_t e_branch(string n, logic tk);
    return mk({n, ".branch"}, 4'd9, tk ? EnPc : 6'd0, 1'b0, tk ? 3'b110 : 3'b100,
              1'b1, 2'd0, 4'b0110, 2'd1, 2'd0, 2'd0);
  endfunction
  function automatic exp_t e_jump(string n, logic jal);
    return mk({n, ".jump"}, 4'd10, jal ? (EnPc | EnRf) : EnPc, 1'b0, jal ? 3'b011 : 3'b010,
              1'b0, 2'd0, 4'd0, 2'd2, 2'd2, 2'd2);
  endfunction
  function automatic exp_t e_jr(string n);
    return mk({n, ".jr"}, 4'd11, EnPc, 1'b0, 3'b010, 1'b0, 2'd0, 4'd0, 2'd3, 2'd0, 2'd0);
  endfunction
  function automatic exp_t e_trap(string n);
    return mk({n, ".trap"}, 4'd15, 6'd0, 1'b1, 3'b000, 1'b0, 2'd0, 4'd0, 2'd0, 2'd0, 2'd0);
  endfunction
  function automatic exp_t e_reset(string n);
    return mk({n, ".reset"}, 4'd0, 6'd0, 1'b0, 3'b000, 1'b0, 2'd0, 4'd0, 2'd0, 2'd0, 2'd0);
  endfunction

  // Monitor: sample 1 time unit after each falling clock edge or reset assertion.
  always @(negedge clk or negedge rst_n) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      logic ok;
      e  = q.pop_front();
      ok = (state == e.st) && (trap == e.trap) &&
           ({pc_we, ir_we, rf_we, mem_rd, mem_wr, tgt_we} == e.en);
      if (e.chk[2]) ok = ok && (alu_src_a == e.a) && (alu_src_b == e.b) && (alu_ctrl == e.alu);
      if (e.chk[1]) ok = ok && (pc_src == e.pcs);
      if (e.chk[0]) ok = ok && (reg_dst == e.rdst) && (wb_src == e.wbs);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got st=%0d en=%b trap=%b a=%b b=%0d alu=%b pcs=%0d rdst=%0d wbs=%0d; exp st=%0d en=%b trap=%b a=%b b=%0d alu=%b pcs=%0d rdst=%0d wbs=%0d chk=%b",
                    e.name, state, {pc_we, ir_we, rf_we, mem_rd, mem_wr, tgt_we}, trap,
                    alu_src_a, alu_src_b, alu_ctrl, pc_src, reg_dst, wb_src,
                    e.st, e.en, e.trap, e.a, e.b, e.alu, e.pcs, e.rdst, e.wbs, e.chk);
    end
  end

  task automatic step(exp_t e);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; reset held low across one rising edge.
  task automatic do_reset(string n);
    q.push_back(e_reset(n));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

`ifdef MEM_WAIT_EN
  localparam logic RdyDflt = 1'b1;
`else
  localparam logic RdyDflt = 1'b0;  // ignored by the default build
`endif

  task automatic run_r(string n, logic [5:0] fn, logic [3:0] alu);
    op = 6'b000000; funct = fn;
    step(e_fetch(n)); step(e_decode(n)); step(e_exec_r(n, alu)); step(e_wb_alu(n, 2'd1));
  endtask

  task automatic run_i(string n, logic [5:0] opc, logic [3:0] alu);
    op = opc; funct = 6'b010101;
    step(e_fetch(n)); step(e_decode(n)); step(e_exec_i(n, alu)); step(e_wb_alu(n, 2'd0));
  endtask

  task automatic run_br(string n, logic [5:0] opc, logic z, logic ng, logic tk);
    op = opc; zero = z; neg = ng;
    step(e_fetch(n)); step(e_decode(n)); step(e_branch(n, tk));
  endtask

  typedef struct { string n; logic [5:0] fn; logic [3:0] alu; } rvec_t;
  rvec_t rtab[10] = '{
    '{"add",  6'b100000, 4'b0010}, '{"sub",  6'b100010, 4'b0110},
    '{"and",  6'b100100, 4'b0000}, '{"or",   6'b100101, 4'b0001},
    '{"slt",  6'b101010, 4'b0111}, '{"sllv", 6'b000100, 4'b1000},
    '{"sll",  6'b000000, 4'b1000}, '{"srlv", 6'b000110, 4'b1001},
    '{"srl",  6'b000010, 4'b1001}, '{"mul",  6'b011000, 4'b1010}
  };

  initial begin
    #1;
    do_reset("init");

    foreach (rtab[i]) run_r(rtab[i].n, rtab[i].fn, rtab[i].alu);

    run_i("addi", 6'b001000, 4'b0010);
    run_i("ori",  6'b001101, 4'b0001);
    run_i("lui",  6'b001111, 4'b1011);

    op = 6'b100011; mem_ready = RdyDflt;
    step(e_fetch("lw")); step(e_decode("lw")); step(e_mem_addr("lw"));
    step(e_mem_rd("lw")); step(e_mem_wb("lw"));

    op = 6'b101011;
    step(e_fetch("sw")); step(e_decode("sw")); step(e_mem_addr("sw")); step(e_mem_wr("sw"));
    mem_ready = 1'b0;

    run_br("beq_t",  6'b000100, 1'b1, 1'b0, 1'b1);
    run_br("beq_nt", 6'b000100, 1'b0, 1'b0, 1'b0);
    run_br("bnez_t", 6'b000101, 1'b0, 1'b1, 1'b1);
    run_br("bnez_n", 6'b000101, 1'b1, 1'b0, 1'b0);
    run_br("bgt_t",  6'b000111, 1'b0, 1'b0, 1'b1);
    run_br("bgt_n",  6'b000111, 1'b0, 1'b1, 1'b0);
    run_br("bgez_t", 6'b000001, 1'b1, 1'b0, 1'b1);
    run_br("bgez_n", 6'b000001, 1'b0, 1'b1, 1'b0);
    zero = 1'b0; neg = 1'b0;

    op = 6'b000010;
    step(e_fetch("j")); step(e_decode("j")); step(e_jump("j", 1'b0));
    op = 6'b000011;
    step(e_fetch("jal")); step(e_decode("jal")); step(e_jump("jal", 1'b1));
    op = 6'b000000; funct = 6'b001000;
    step(e_fetch("jr")); step(e_decode("jr")); step(e_jr("jr"));

    // Unknown funct traps from EXEC_R.
    op = 6'b000000; funct = 6'b111111;
    step(e_fetch("badfn")); step(e_decode("badfn")); step(e_exec_r("badfn", 4'b0010));
    step(e_trap("badfn")); step(e_trap("badfn"));
    do_reset("badfn");

    // Illegal opcode: trap is sticky until reset, then normal fetch resumes.
    op = 6'b111111; funct = 6'b100000;
    step(e_fetch("badop")); step(e_decode("badop"));
    for (int i = 0; i < 3; i++) step(e_trap("badop"));
    do_reset("badop");
    op = 6'b000010;
    step(e_fetch("rec")); step(e_decode("rec")); step(e_jump("rec", 1'b0));

`ifdef MEM_WAIT_EN
    // Ready arrives on the 4th MEM_RD cycle.
    op = 6'b100011; mem_ready = 1'b0;
    step(e_fetch("lww")); step(e_decode("lww")); step(e_mem_addr("lww"));
    for (int i = 0; i < 3; i++) step(e_mem_rd("lww"));
    mem_ready = 1'b1;
    step(e_mem_rd("lww"));
    mem_ready = 1'b0;
    step(e_mem_wb("lww"));

    // Never ready: 15 MEM_RD cycles, then trap.
    step(e_fetch("lwto")); step(e_decode("lwto")); step(e_mem_addr("lwto"));
    for (int i = 0; i < 15; i++) step(e_mem_rd("lwto"));
    step(e_trap("lwto")); step(e_trap("lwto"));
    do_reset("lwto");
`endif

    // Reset mid MEM_WR: mem_wr must drop before the next clock edge.
    op = 6'b101011; mem_ready = 1'b0;
    step(e_fetch("swrst")); step(e_decode("swrst")); step(e_mem_addr("swrst"));
    q.push_back(e_mem_wr("swrst"));
    @(negedge clk);
    #2;
    do_reset("swrst");
    op = 6'b000011;
    step(e_fetch("post")); step(e_decode("post")); step(e_jump("post", 1'b1));

    repeat (2) @(negedge clk);
    #2;
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d unchecked entries, exp 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000, exp finish");
    $fatal(1, "watchdog");
  end

endmodule
